// File: rtl/i2c_pkg.sv
// i2c_pkg: shared definitions for the byte-level I2C master engine.
//   - i2c_state_t : transaction FSM states
//   - i2c_phase_t : quarter-bit phase (q0..q3)
//   - I2C_ACK / I2C_NACK : SDA level of an acknowledge / not-acknowledge bit
//   - i2c_txn_quarters() : transaction length in SCL quarters
package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_DATA,
      ST_DATA_ACK,
      ST_STOP
   } i2c_state_t;

   typedef enum logic [1:0] {
      PH_Q0 = 2'd0,   // SCL low, SDA updated
      PH_Q1 = 2'd1,   // SCL released
      PH_Q2 = 2'd2,   // SCL high, SDA sampled at the end
      PH_Q3 = 2'd3    // SCL low
   } i2c_phase_t;

   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;

   localparam int START_QUARTERS = 3;
   localparam int BYTE_QUARTERS  = 36;   // 8 bits + ack, 4 quarters each
   localparam int STOP_QUARTERS  = 4;

   // Full-length (no abort) transaction in quarters; two_bytes selects 1 or 2 data bytes.
   function automatic int i2c_txn_quarters(input logic two_bytes);
      return START_QUARTERS + BYTE_QUARTERS * (two_bytes ? 3 : 2) + STOP_QUARTERS;
   endfunction

endpackage

// File: rtl/i2c_master_engine_quarter_tick.sv
// i2c_quarter_tick: quarter-SCL-period prescaler.
//   clk, rst_n : clock, asynchronous active-low reset
//   restart    : restart the count at the start of a quarter in phase q1
//                (a transaction's START occupies phases q1..q3)
//   stall      : freeze the count (target clock stretching)
//   tick       : one-cycle pulse in the last cycle of each quarter
//   phase      : current quarter phase (advances after each tick)
module i2c_quarter_tick
   import i2c_pkg::*;
#(
   parameter int CLK_DIV = 250
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       restart,
   input  logic       stall,
   output logic       tick,
   output logic [1:0] phase
);

   localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_reg;

   assign tick = (cnt_reg == CNT_MAX) && !stall && !restart;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
         phase   <= PH_Q0;
      end else if (restart) begin
         cnt_reg <= '0;
         phase   <= PH_Q1;
      end else if (!stall) begin
         if (cnt_reg == CNT_MAX) begin
            cnt_reg <= '0;
            phase   <= phase + 2'd1;
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

endmodule

// File: rtl/i2c_master_engine.sv
// i2c_master_engine: byte-level I2C master for the DAC control FSM.
// One transaction per I2C_load: START, {addr,r/w}, 1 or 2 data bytes with
// ACK/NACK, STOP. All outputs are registered.
//   CLK_DIV        : system clocks per quarter SCL period (>= 2)
//   clk, rst_n     : clock, asynchronous active-low reset
//   I2Caddr/I2Cdata/I2Cbytes/I2Cr_w/I2C_load : request (latched on load in IDLE)
//   I2CBusy        : transaction in progress
//   I2CDataReady   : one-cycle completion pulse (reads, writes, aborts)
//   I2Crd_data     : read result, I2Cack_err : a NACK was seen
//   scl_in/sda_in  : synchronized pin levels
//   scl_drive_low/sda_drive_low : 1 pulls the open-drain line low
// Optional feature: define I2C_CLOCK_STRETCH_EN to honour target clock
// stretching (counter waits for scl_in=1 in q1 and in the STOP bus-free quarter).
module i2c_master_engine
   import i2c_pkg::*;
#(
   parameter int CLK_DIV = 250
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  I2Caddr,
   input  logic [15:0] I2Cdata,
   input  logic        I2Cbytes,
   input  logic        I2Cr_w,
   input  logic        I2C_load,
   output logic        I2CBusy,
   output logic        I2CDataReady,
   output logic [15:0] I2Crd_data,
   output logic        I2Cack_err,
   input  logic        scl_in,
   input  logic        sda_in,
   output logic        scl_drive_low,
   output logic        sda_drive_low
);

   i2c_state_t  state_reg;
   logic [7:0]  shift_reg;
   logic [2:0]  bit_cnt_reg;
   logic        byte_cnt_reg;     // index of the data byte in flight
   logic [15:0] data_reg;
   logic        two_reg;
   logic        rw_reg;
   logic        sample_reg;       // SDA captured at the end of q2

   logic        tick;
   logic        stall;
   logic        restart;
   logic [1:0]  phase_bits;
   i2c_phase_t  phase;
   logic        bit_state;
   logic        last_byte;
   logic [7:0]  first_byte;

   assign phase      = i2c_phase_t'(phase_bits);
   assign restart    = (state_reg == ST_IDLE) && I2C_load;
   assign bit_state  = (state_reg == ST_ADDR) || (state_reg == ST_ADDR_ACK) ||
                       (state_reg == ST_DATA) || (state_reg == ST_DATA_ACK);
   assign last_byte  = (byte_cnt_reg == two_reg);
   assign first_byte = two_reg ? data_reg[15:8] : data_reg[7:0];

`ifdef I2C_CLOCK_STRETCH_EN
   assign stall = !scl_in && ((bit_state && (phase == PH_Q1)) ||
                              ((state_reg == ST_STOP) && (phase == PH_Q3)));
`else
   logic unused_scl_in;
   assign unused_scl_in = scl_in;
   assign stall         = 1'b0;
`endif

   i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (restart),
      .stall   (stall),
      .tick    (tick),
      .phase   (phase_bits)
   );

   // Each tick ends the current quarter; the registers below take the values
   // for the quarter that starts next.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         shift_reg     <= '0;
         bit_cnt_reg   <= '0;
         byte_cnt_reg  <= 1'b0;
         data_reg      <= '0;
         two_reg       <= 1'b0;
         rw_reg        <= 1'b0;
         sample_reg    <= 1'b0;
         I2CBusy       <= 1'b0;
         I2CDataReady  <= 1'b0;
         I2Crd_data    <= '0;
         I2Cack_err    <= 1'b0;
         scl_drive_low <= 1'b0;
         sda_drive_low <= 1'b0;
      end else begin
         I2CDataReady <= 1'b0;
         if (state_reg == ST_IDLE) begin
            if (I2C_load) begin
               shift_reg     <= {I2Caddr, I2Cr_w};
               data_reg      <= I2Cdata;
               two_reg       <= I2Cbytes;
               rw_reg        <= I2Cr_w;
               I2Cack_err    <= 1'b0;
               I2Crd_data    <= '0;
               I2CBusy       <= 1'b1;
               scl_drive_low <= 1'b0;
               sda_drive_low <= 1'b0;
               state_reg     <= ST_START;
            end
         end else if (tick) begin
            case (state_reg)
               ST_START: begin
                  // q1: bus idle, q2..q3: SDA low with SCL high
                  if (phase == PH_Q1) begin
                     sda_drive_low <= 1'b1;
                  end else if (phase == PH_Q3) begin
                     state_reg     <= ST_ADDR;
                     bit_cnt_reg   <= '0;
                     scl_drive_low <= 1'b1;
                     sda_drive_low <= ~shift_reg[7];
                  end
               end

               ST_ADDR, ST_ADDR_ACK, ST_DATA, ST_DATA_ACK: begin
                  case (phase)
                     PH_Q0: scl_drive_low <= 1'b0;
                     PH_Q2: begin
                        scl_drive_low <= 1'b1;
                        sample_reg    <= sda_in;
                        if ((state_reg == ST_DATA) && rw_reg)
                           shift_reg <= {shift_reg[6:0], sda_in};
                     end
                     PH_Q3: begin
                        case (state_reg)
                           ST_ADDR: begin
                              if (bit_cnt_reg == 3'd7) begin
                                 state_reg     <= ST_ADDR_ACK;
                                 sda_drive_low <= 1'b0;
                              end else begin
                                 bit_cnt_reg   <= bit_cnt_reg + 3'd1;
                                 shift_reg     <= {shift_reg[6:0], 1'b0};
                                 sda_drive_low <= ~shift_reg[6];
                              end
                           end
                           ST_ADDR_ACK: begin
                              if (sample_reg == I2C_NACK) begin
                                 I2Cack_err    <= 1'b1;
                                 state_reg     <= ST_STOP;
                                 sda_drive_low <= 1'b1;
                              end else begin
                                 state_reg    <= ST_DATA;
                                 bit_cnt_reg  <= '0;
                                 byte_cnt_reg <= 1'b0;
                                 if (rw_reg) begin
                                    sda_drive_low <= 1'b0;
                                 end else begin
                                    shift_reg     <= first_byte;
                                    sda_drive_low <= ~first_byte[7];
                                 end
                              end
                           end
                           ST_DATA: begin
                              if (bit_cnt_reg == 3'd7) begin
                                 state_reg <= ST_DATA_ACK;
                                 if (rw_reg) begin
                                    // master ACKs every byte but the last
                                    sda_drive_low <= last_byte ? ~I2C_NACK : ~I2C_ACK;
                                    if (two_reg && !byte_cnt_reg)
                                       I2Crd_data[15:8] <= shift_reg;
                                    else
                                       I2Crd_data[7:0]  <= shift_reg;
                                 end else begin
                                    sda_drive_low <= 1'b0;
                                 end
                              end else begin
                                 bit_cnt_reg <= bit_cnt_reg + 3'd1;
                                 if (!rw_reg) begin
                                    shift_reg     <= {shift_reg[6:0], 1'b0};
                                    sda_drive_low <= ~shift_reg[6];
                                 end
                              end
                           end
                           ST_DATA_ACK: begin
                              if (!rw_reg && (sample_reg == I2C_NACK)) begin
                                 I2Cack_err    <= 1'b1;
                                 state_reg     <= ST_STOP;
                                 sda_drive_low <= 1'b1;
                              end else if (last_byte) begin
                                 state_reg     <= ST_STOP;
                                 sda_drive_low <= 1'b1;
                              end else begin
                                 state_reg    <= ST_DATA;
                                 bit_cnt_reg  <= '0;
                                 byte_cnt_reg <= 1'b1;
                                 if (rw_reg) begin
                                    sda_drive_low <= 1'b0;
                                 end else begin
                                    shift_reg     <= data_reg[7:0];
                                    sda_drive_low <= ~data_reg[7];
                                 end
                              end
                           end
                           default: ;
                        endcase
                     end
                     default: ;
                  endcase
               end

               ST_STOP: begin
                  // q0: SDA low/SCL low, q1: SCL up, q2: SDA up, q3: bus free
                  case (phase)
                     PH_Q0: scl_drive_low <= 1'b0;
                     PH_Q1: sda_drive_low <= 1'b0;
                     PH_Q3: begin
                        state_reg    <= ST_IDLE;
                        I2CBusy      <= 1'b0;
                        I2CDataReady <= 1'b1;
                     end
                     default: ;
                  endcase
               end

               default: state_reg <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/i2c_master_engine.md
# i2c_master_engine

Byte-level I2C master serving the DAC control FSM's request interface. Accepts one latched transaction per `I2C_load` (7-bit address, read/write, one or two data bytes) and generates START, address, data, ACK/NACK and STOP on open-drain SCL/SDA. It reports progress on `I2CBusy` and completion on `I2CDataReady`. It sits between the DAC control FSM and the board's DAC I2C pins.

## Interface
- `CLK_DIV`, 250: system clocks per quarter SCL period (100 MHz → 100 kHz); minimum 2
- `clk` in 1: system clock
- `rst_n` in 1: asynchronous, active-low reset
- `I2Caddr` in 7: target address
- `I2Cdata` in 16: write payload
- `I2Cbytes` in 1: 0 = one data byte, 1 = two data bytes
- `I2Cr_w` in 1: 0 = write, 1 = read
- `I2C_load` in 1: request strobe
- `I2CBusy` out 1: transaction in progress
- `I2CDataReady` out 1: one-cycle completion pulse
- `I2Crd_data` out 16: read result
- `I2Cack_err` out 1: last transaction saw a NACK
- `scl_in`, `sda_in` in 1: synchronized pin levels
- `scl_drive_low`, `sda_drive_low` out 1: 1 pulls the line low; 0 releases it

## Operation
- States: IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP.
- IDLE behaviour:
  - `I2C_load`=1 latches all request inputs and clears `I2Cack_err` and `I2Crd_data`, then goes to START.
  - `I2C_load` while busy is ignored.
  - Request inputs are don't-care after the latch cycle.
- Bit timing: each bit is 4 quarters.
  - q0: SCL low, SDA updated.
  - q1: SCL released.
  - q2: SCL high, SDA sampled at the end of q2.
  - q3: SCL low.
- START: SDA pulled low while SCL is high for 2 quarters, then SCL pulled low.
- ADDR: shifts `{I2Caddr, I2Cr_w}`, MSB first.
- ADDR_ACK: SDA released. If SDA is sampled high (NACK), set `I2Cack_err` and go to STOP.
- Write DATA order:
  - Two bytes: `I2Cdata[15:8]` then `[7:0]`.
  - One byte: `[7:0]` only.
  - A NACK on any data byte sets `I2Cack_err` and goes to STOP; remaining bytes are skipped.
- Read DATA:
  - SDA released; 8 bits sampled MSB first.
  - Master drives ACK (SDA low) after every byte except the last, and NACK (released) after the last.
  - Two bytes: first byte → `I2Crd_data[15:8]`, second → `[7:0]`.
  - One byte: `[7:0]`, upper byte 0.
- STOP: SDA low with SCL low, then SCL released, then SDA released; 1 quarter each plus 1 bus-free quarter.
- Completion:
  - `I2CDataReady` pulses for exactly one cycle as the FSM returns to IDLE, for reads, writes and aborts alike.
  - `I2Crd_data` and `I2Cack_err` are valid from that cycle and held until the next load.
- Reset mid-transaction: both lines are released immediately and the FSM returns to IDLE. A truncated frame on the bus is accepted.

## Timing
- Reset values:
  - `I2CBusy`=0, `I2CDataReady`=0, `I2Crd_data`=0, `I2Cack_err`=0.
  - `scl_drive_low`=0, `sda_drive_low`=0.
  - Quarter counter = 0, state = IDLE.
- Load accepted in cycle t:
  - `I2CBusy`=1 from cycle t+1.
  - The first SDA fall occurs at t+1+CLK_DIV.
- `I2CBusy` falls in the same cycle `I2CDataReady` pulses. A new load is accepted in that cycle + 1.
- Full transaction length, in quarters (Q = CLK_DIV cycles): 3 (START) + 36 × (1 + bytes) + 4 (STOP).
  - One byte: 79 Q.
  - Two bytes: 115 Q.
- No combinational path from any input to any output; all outputs are registered.

## Configuration
- `I2C_CLOCK_STRETCH_EN`:
  - Defined: after releasing SCL in q1, the quarter counter holds until `scl_in` reads 1 (target clock stretching). The bus-free quarter in STOP also waits for `scl_in`=1.
  - Undefined: `scl_in` is ignored and timing is purely counter-driven.

## Structure
- Package `i2c_pkg`: state enum, quarter-phase enum, `I2C_ACK`/`I2C_NACK` constants, a function for transaction length in quarters.
- Sub-module `i2c_quarter_tick`: CLK_DIV prescaler producing a one-cycle tick and 2-bit phase. It carries a stall input used by stretching.
- Shift register, bit counter and byte counter live in the top module.

## Test plan
- Bench setup: `CLK_DIV`=4 and a behavioural I2C target model at address 0x4C.
- Write, 2 bytes, addr 0x4C, data 0xA55A → bus shows START, 0x98, ACK, 0xA5, ACK, 0x5A, ACK, STOP. `I2CDataReady` pulses once 460 cycles after busy rise; `I2Cack_err`=0.
- Read, 2 bytes, target returns 0x12, 0x34 → `I2Crd_data`=0x1234. Master ACKs the first byte and NACKs the second; address byte 0x99.
- Write to absent addr 0x20 → NACK at ADDR_ACK, STOP follows immediately, `I2Cack_err`=1, no data bytes on the bus.
- `I2C_load` pulsed again while busy with different data → ignored; the bus carries only the first transaction. Back-to-back load in the cycle after `I2CDataReady` is accepted.
- `rst_n` asserted during the 2nd data byte → both drive outputs 0 and `I2CBusy`=0 in the same cycle; a later load completes normally.
- With `I2C_CLOCK_STRETCH_EN`, target holds SCL low 20 cycles on bit 3 → transaction lengthens by exactly the stretch, and data is intact.
